// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared DataMemory.
// The arbiter uses the slave view; requesters/memory model use the master view.
interface data_memory_arbiter_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  Req0, Req1;
  logic                  Wr0, Wr1;
  logic [DATA_WIDTH-1:0] Addr0, Addr1;
  logic [DATA_WIDTH-1:0] WData0, WData1;
  logic                  Ack0, Ack1;
  logic [DATA_WIDTH-1:0] RData0, RData1;
  logic [DATA_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemWriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] MemReadData;
  logic                  Busy;

  modport slave (
    input  Req0, Req1, Wr0, Wr1, Addr0, Addr1, WData0, WData1, MemReadData,
    output Ack0, Ack1, RData0, RData1, MemAddress, MemWriteData, MemWrite,
           MemRead, Busy
  );

  modport master (
    output Req0, Req1, Wr0, Wr1, Addr0, Addr1, WData0, WData1, MemReadData,
    input  Ack0, Ack1, RData0, RData1, MemAddress, MemWriteData, MemWrite,
           MemRead, Busy
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared DataMemory.
// One access at a time: IDLE (arbitrate) -> ACCESS (WAIT_CYCLES) -> DONE (Ack).
// MemAddress/MemWriteData double as the latched address/data of the access.
module data_memory_arbiter #(
  parameter int DATA_WIDTH  = 24,
  parameter int WAIT_CYCLES = 1
) (
  input logic                  Clock,
  input logic                  Reset,
  data_memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant;
  logic       wr;
  logic       req_any;
  logic       pick;
  logic       wr_sel;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    req_any = bus.Req0 | bus.Req1;
    pick    = bus.Req1;
    if (bus.Req0 && bus.Req1) pick = ~last_grant;
    wr_sel  = pick ? bus.Wr1 : bus.Wr0;
  end

  // Sequencer FSM; every memory-side and port-side output is registered here.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      last_grant       <= 1'b1;
      grant            <= 1'b0;
      wr               <= 1'b0;
      bus.Ack0         <= 1'b0;
      bus.Ack1         <= 1'b0;
      bus.RData0       <= '0;
      bus.RData1       <= '0;
      bus.MemAddress   <= '0;
      bus.MemWriteData <= '0;
      bus.MemWrite     <= 1'b0;
      bus.MemRead      <= 1'b0;
      bus.Busy         <= 1'b0;
    end else begin
      bus.Ack0 <= 1'b0;
      bus.Ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state            <= ACCESS;
            grant            <= pick;
            last_grant       <= pick;
            wr               <= wr_sel;
            cnt              <= CNT_INIT;
            bus.MemAddress   <= pick ? bus.Addr1 : bus.Addr0;
            bus.MemWriteData <= pick ? bus.WData1 : bus.WData0;
            bus.MemRead      <= ~wr_sel;
            // Write strobe only in the final ACCESS cycle: one write edge.
            bus.MemWrite     <= wr_sel && (CNT_INIT == 4'd0);
            bus.Busy         <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state        <= DONE;
            bus.MemRead  <= 1'b0;
            bus.MemWrite <= 1'b0;
            if (grant) bus.Ack1 <= 1'b1;
            else       bus.Ack0 <= 1'b1;
            if (!wr) begin
              if (grant) bus.RData1 <= bus.MemReadData;
              else       bus.RData0 <= bus.MemReadData;
            end
          end else begin
            cnt          <= cnt - 4'd1;
            bus.MemWrite <= wr && (cnt == 4'd1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.Busy     <= 1'b0;
          bus.MemRead  <= 1'b0;
          bus.MemWrite <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench: DUT a uses WAIT_CYCLES=1, DUT b uses WAIT_CYCLES=3.
// Each has a 16-entry memory model indexed by the low address bits.
module tb_data_memory_arbiter;
  logic clk = 1'b0;
  logic rst_a, rst_b, mem_clear;
  int   total = 0;
  int   bad   = 0;
  int   wcnt_a, wcnt_b, rcnt_b, excl_err;
  logic [23:0] waddr_a, wdat_a;
  logic [23:0] mem_a [0:15];
  logic [23:0] mem_b [0:15];

  always #5 clk = ~clk;

  data_memory_arbiter_if #(.DATA_WIDTH(24)) ba ();
  data_memory_arbiter_if #(.DATA_WIDTH(24)) bb ();

  data_memory_arbiter #(.DATA_WIDTH(24), .WAIT_CYCLES(1)) dut_a (
    .Clock(clk), .Reset(rst_a), .bus(ba.slave));
  data_memory_arbiter #(.DATA_WIDTH(24), .WAIT_CYCLES(3)) dut_b (
    .Clock(clk), .Reset(rst_b), .bus(bb.slave));

  assign ba.MemReadData = mem_a[ba.MemAddress[3:0]];
  assign bb.MemReadData = mem_b[bb.MemAddress[3:0]];

  // Memory models: clear to 0x100+i, otherwise write on MemWrite.
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (mem_clear) begin
        mem_a[i] <= 24'h000100 + 24'(i);
        mem_b[i] <= 24'h000100 + 24'(i);
      end
    end
    if (!mem_clear && ba.MemWrite) mem_a[ba.MemAddress[3:0]] <= ba.MemWriteData;
    if (!mem_clear && bb.MemWrite) mem_b[bb.MemAddress[3:0]] <= bb.MemWriteData;
  end

  // Strobe counters and exclusivity watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (ba.MemWrite) begin
      wcnt_a++;
      waddr_a = ba.MemAddress;
      wdat_a  = ba.MemWriteData;
    end
    if (bb.MemWrite) wcnt_b++;
    if (bb.MemRead)  rcnt_b++;
    if ((ba.Ack0 && ba.Ack1) || (ba.MemRead && ba.MemWrite)) excl_err++;
    if ((bb.Ack0 && bb.Ack1) || (bb.MemRead && bb.MemWrite)) excl_err++;
  end

  // One request on DUT a, held until its Ack; lat = cycles from request to Ack.
  task automatic issue_a(input bit port, input bit w, input logic [23:0] a,
                         input logic [23:0] d, output int lat);
    @(negedge clk);
    if (port) begin ba.Wr1 = w; ba.Addr1 = a; ba.WData1 = d; ba.Req1 = 1'b1; end
    else      begin ba.Wr0 = w; ba.Addr0 = a; ba.WData0 = d; ba.Req0 = 1'b1; end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (port ? ba.Ack1 : ba.Ack0) begin lat = k; break; end
    end
    if (port) ba.Req1 = 1'b0; else ba.Req0 = 1'b0;
  endtask

  task automatic issue_b(input bit port, input bit w, input logic [23:0] a,
                         input logic [23:0] d, output int lat);
    @(negedge clk);
    if (port) begin bb.Wr1 = w; bb.Addr1 = a; bb.WData1 = d; bb.Req1 = 1'b1; end
    else      begin bb.Wr0 = w; bb.Addr0 = a; bb.WData0 = d; bb.Req0 = 1'b1; end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (port ? bb.Ack1 : bb.Ack0) begin lat = k; break; end
    end
    if (port) bb.Req1 = 1'b0; else bb.Req0 = 1'b0;
  endtask

  task automatic test_reset;
    logic [124:0] oa, ob;
    {ba.Req0, ba.Req1, ba.Wr0, ba.Wr1} = '0;
    {ba.Addr0, ba.Addr1, ba.WData0, ba.WData1} = '0;
    {bb.Req0, bb.Req1, bb.Wr0, bb.Wr1} = '0;
    {bb.Addr0, bb.Addr1, bb.WData0, bb.WData1} = '0;
    wcnt_a = 0; wcnt_b = 0; rcnt_b = 0; excl_err = 0;
    rst_a = 1'b1; rst_b = 1'b1; mem_clear = 1'b1;
    repeat (2) @(negedge clk);
    oa = {ba.Ack0, ba.Ack1, ba.RData0, ba.RData1, ba.MemAddress, ba.MemWriteData,
          ba.MemWrite, ba.MemRead, ba.Busy};
    ob = {bb.Ack0, bb.Ack1, bb.RData0, bb.RData1, bb.MemAddress, bb.MemWriteData,
          bb.MemWrite, bb.MemRead, bb.Busy};
    total++; if (oa !== '0) begin bad++; $display("FAIL reset_a got=%0h exp=0", oa); end
    total++; if (ob !== '0) begin bad++; $display("FAIL reset_b got=%0h exp=0", ob); end
    mem_clear = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_write_read;
    int lat;
    wcnt_a = 0;
    issue_a(1'b0, 1'b1, 24'd2, 24'd7, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    total++; if (wcnt_a != 1) begin bad++; $display("FAIL wr_strobes got=%0d exp=1", wcnt_a); end
    total++; if (waddr_a !== 24'd2) begin bad++; $display("FAIL wr_addr got=%0h exp=2", waddr_a); end
    total++; if (wdat_a !== 24'd7) begin bad++; $display("FAIL wr_data got=%0h exp=7", wdat_a); end
    issue_a(1'b0, 1'b0, 24'd2, 24'd0, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    total++; if (ba.RData0 !== 24'd7) begin bad++; $display("FAIL rd_data0 got=%0h exp=7", ba.RData0); end
  endtask

  task automatic test_reset_async;
    logic [124:0] oa;
    @(negedge clk);
    ba.Wr0 = 1'b1; ba.Addr0 = 24'd3; ba.WData0 = 24'h55; ba.Req0 = 1'b1;
    @(negedge clk);
    #1 rst_a = 1'b1;
    #1;
    oa = {ba.Ack0, ba.Ack1, ba.RData0, ba.RData1, ba.MemAddress, ba.MemWriteData,
          ba.MemWrite, ba.MemRead, ba.Busy};
    total++; if (oa !== '0) begin bad++; $display("FAIL async_reset got=%0h exp=0", oa); end
    ba.Req0 = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_simultaneous;
    int a0_at = 0, a1_at = 0;
    logic [5:1] busy_v = '0;
    logic [23:0] r1 = '0;
    @(negedge clk);
    ba.Wr0 = 1'b1; ba.Addr0 = 24'd5; ba.WData0 = 24'h00AAAA; ba.Req0 = 1'b1;
    ba.Wr1 = 1'b0; ba.Addr1 = 24'd5; ba.WData1 = 24'h0; ba.Req1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 5) busy_v[k] = ba.Busy;
      if (ba.Ack0 && a0_at == 0) begin a0_at = k; ba.Req0 = 1'b0; end
      if (ba.Ack1 && a1_at == 0) begin a1_at = k; r1 = ba.RData1; ba.Req1 = 1'b0; end
      if (a1_at > 0) break;
    end
    ba.Req0 = 1'b0; ba.Req1 = 1'b0;
    total++; if (a0_at != 2) begin bad++; $display("FAIL sim_ack0_cycle got=%0d exp=2", a0_at); end
    total++; if (a1_at != 5) begin bad++; $display("FAIL sim_ack1_cycle got=%0d exp=5", a1_at); end
    total++; if (busy_v !== 5'b11011) begin bad++; $display("FAIL sim_busy got=%b exp=11011", busy_v); end
    total++; if (r1 !== 24'h00AAAA) begin bad++; $display("FAIL sim_rdata1 got=%0h exp=aaaa", r1); end
  endtask

  task automatic test_fairness;
    logic [5:0] ord = '0;
    int n = 0, last_at = 0;
    @(negedge clk);
    ba.Wr0 = 1'b0; ba.Addr0 = 24'd1; ba.Req0 = 1'b1;
    ba.Wr1 = 1'b0; ba.Addr1 = 24'd4; ba.Req1 = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ba.Ack0 || ba.Ack1) begin
        ord[n] = ba.Ack1;
        n++;
        if (n == 6) begin last_at = k; break; end
      end
    end
    ba.Req0 = 1'b0; ba.Req1 = 1'b0;
    total++; if (ord !== 6'b101010 || n != 6) begin bad++; $display("FAIL fair_order got=%b n=%0d exp=101010 n=6", ord, n); end
    total++; if (last_at != 17) begin bad++; $display("FAIL fair_span got=%0d exp=17", last_at); end
  endtask

  task automatic test_wait3;
    int lat;
    rcnt_b = 0;
    issue_b(1'b1, 1'b0, 24'd9, 24'd0, lat);
    total++; if (lat != 4) begin bad++; $display("FAIL w3_latency got=%0d exp=4", lat); end
    total++; if (rcnt_b != 3) begin bad++; $display("FAIL w3_read_cycles got=%0d exp=3", rcnt_b); end
    total++; if (bb.RData1 !== 24'h000109) begin bad++; $display("FAIL w3_rdata1 got=%0h exp=109", bb.RData1); end
  endtask

  task automatic test_reset_access;
    int acks = 0, lat;
    wcnt_b = 0;
    @(negedge clk);
    bb.Wr0 = 1'b1; bb.Addr0 = 24'd9; bb.WData0 = 24'h123456; bb.Req0 = 1'b1;
    @(negedge clk);
    #1 rst_b = 1'b1;
    bb.Req0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bb.Ack0 || bb.Ack1) acks++;
    end
    rst_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bb.Ack0 || bb.Ack1) acks++;
    end
    total++; if (wcnt_b != 0) begin bad++; $display("FAIL ra_write_strobes got=%0d exp=0", wcnt_b); end
    total++; if (acks != 0) begin bad++; $display("FAIL ra_acks got=%0d exp=0", acks); end
    issue_b(1'b0, 1'b0, 24'd9, 24'd0, lat);
    total++; if (lat != 4) begin bad++; $display("FAIL ra_rd_latency got=%0d exp=4", lat); end
    total++; if (bb.RData0 !== 24'h000109) begin bad++; $display("FAIL ra_rdata0 got=%0h exp=109", bb.RData0); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_reset_async;
    test_simultaneous;
    test_fairness;
    test_wait3;
    test_reset_access;
    @(negedge clk);
    total++; if (excl_err != 0) begin bad++; $display("FAIL exclusivity got=%0d exp=0", excl_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
